// File: rtl/spi_master_cs_ctrl_pkg.sv
// Shared definitions for the chip-select transaction layer: FSM states and sizing helpers.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD,
    GAP
  } state_e;

  // Bits needed to hold values 0..max_val inclusive.
  function automatic int cw_f(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int max_f(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_master_cs_ctrl_if.sv
// User-side byte handshake of the chip-select transaction layer.
interface spi_master_cs_ctrl_if #(
  parameter int CW = 2
);
  logic [CW-1:0] i_TX_Count;
  logic [7:0]    i_TX_Byte;
  logic          i_TX_DV;
  logic          o_TX_Ready;
  logic [CW-1:0] o_RX_Count;
  logic          o_RX_DV;
  logic [7:0]    o_RX_Byte;

  modport master (
    output i_TX_Count, i_TX_Byte, i_TX_DV,
    input  o_TX_Ready, o_RX_Count, o_RX_DV, o_RX_Byte
  );

  modport slave (
    input  i_TX_Count, i_TX_Byte, i_TX_DV,
    output o_TX_Ready, o_RX_Count, o_RX_DV, o_RX_Byte
  );
endinterface

// File: rtl/spi_master_cs_ctrl_spi_master.sv
// Byte-level SPI engine: shifts one byte out on MOSI and in from MISO per i_TX_DV, modes 0..3.
module SPI_Master #(
  parameter int SPI_MODE          = 0,
  parameter int CLKS_PER_HALF_BIT = 2
) (
  input  logic       i_Rst_L,
  input  logic       i_Clk,
  input  logic [7:0] i_TX_Byte,
  input  logic       i_TX_DV,
  output logic       o_TX_Ready,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_SPI_Clk,
  input  logic       i_SPI_MISO,
  output logic       o_SPI_MOSI
);
  localparam logic CPOL = (SPI_MODE == 2) || (SPI_MODE == 3);
  localparam logic CPHA = (SPI_MODE == 1) || (SPI_MODE == 3);
  localparam int   HW   = $clog2(CLKS_PER_HALF_BIT * 2);
  localparam logic [HW-1:0] LEAD_AT  = HW'(CLKS_PER_HALF_BIT - 1);
  localparam logic [HW-1:0] TRAIL_AT = HW'(2 * CLKS_PER_HALF_BIT - 1);

  logic [HW-1:0] r_Cnt;
  logic [4:0]    r_Edges;
  logic          r_Lead, r_Trail, r_SPI_Clk, r_Ready, r_TX_DV, r_MOSI, r_RX_DV;
  logic [7:0]    r_TX_Byte, r_RX_Byte;
  logic [2:0]    r_TX_Bit, r_RX_Bit;
  logic          w_Drive, w_Sample;

  // CPHA=0 drives on trailing and samples on leading edges; CPHA=1 the reverse.
  assign w_Drive  = CPHA ? r_Lead  : r_Trail;
  assign w_Sample = CPHA ? r_Trail : r_Lead;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_Ready   <= 1'b0;
      r_Edges   <= '0;
      r_Cnt     <= '0;
      r_Lead    <= 1'b0;
      r_Trail   <= 1'b0;
      r_SPI_Clk <= CPOL;
    end else begin
      r_Lead  <= 1'b0;
      r_Trail <= 1'b0;
      if (i_TX_DV) begin
        r_Ready <= 1'b0;
        r_Edges <= 5'd16;
      end else if (r_Edges != 5'd0) begin
        r_Ready <= 1'b0;
        if (r_Cnt == TRAIL_AT) begin
          r_Edges   <= r_Edges - 5'd1;
          r_Trail   <= 1'b1;
          r_Cnt     <= '0;
          r_SPI_Clk <= ~r_SPI_Clk;
        end else if (r_Cnt == LEAD_AT) begin
          r_Edges   <= r_Edges - 5'd1;
          r_Lead    <= 1'b1;
          r_Cnt     <= r_Cnt + HW'(1);
          r_SPI_Clk <= ~r_SPI_Clk;
        end else begin
          r_Cnt <= r_Cnt + HW'(1);
        end
      end else begin
        r_Ready <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_TX_DV   <= 1'b0;
      r_TX_Byte <= '0;
      r_TX_Bit  <= 3'd7;
      r_MOSI    <= 1'b0;
    end else begin
      r_TX_DV <= i_TX_DV;
      if (i_TX_DV) r_TX_Byte <= i_TX_Byte;
      if (r_Ready) begin
        r_TX_Bit <= 3'd7;
      end else if (r_TX_DV && !CPHA) begin
        r_MOSI   <= r_TX_Byte[7];
        r_TX_Bit <= 3'd6;
      end else if (w_Drive) begin
        r_MOSI   <= r_TX_Byte[r_TX_Bit];
        r_TX_Bit <= r_TX_Bit - 3'd1;
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_RX_Byte <= '0;
      r_RX_Bit  <= 3'd7;
      r_RX_DV   <= 1'b0;
    end else begin
      r_RX_DV <= 1'b0;
      if (r_Ready) begin
        r_RX_Bit <= 3'd7;
      end else if (w_Sample) begin
        r_RX_Byte[r_RX_Bit] <= i_SPI_MISO;
        r_RX_Bit            <= r_RX_Bit - 3'd1;
        if (r_RX_Bit == 3'd0) r_RX_DV <= 1'b1;
      end
    end
  end

  assign o_TX_Ready = r_Ready;
  assign o_RX_DV    = r_RX_DV;
  assign o_RX_Byte  = r_RX_Byte;
  assign o_SPI_Clk  = r_SPI_Clk;
  assign o_SPI_MOSI = r_MOSI;

endmodule

// File: rtl/spi_master_cs_ctrl.sv
// Frames N-byte SPI transfers under one active-low chip select and feeds bytes to the engine.
module spi_master_cs_ctrl
  import spi_pkg::*;
#(
  parameter int SPI_MODE          = 0,
  parameter int CLKS_PER_HALF_BIT = 2,
  parameter int MAX_BYTES_PER_CS  = 2,
  parameter int CS_SETUP_CLKS     = 1,
  parameter int CS_INACTIVE_CLKS  = 1
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_L,
  spi_master_cs_ctrl_if.slave  io_if,
  output logic                 o_SPI_Clk,
  input  logic                 i_SPI_MISO,
  output logic                 o_SPI_MOSI,
  output logic                 o_SPI_CS_n
);
  localparam int CW    = cw_f(MAX_BYTES_PER_CS);
  localparam int CYC_W = cw_f(max_f(CS_SETUP_CLKS, CS_INACTIVE_CLKS));
  localparam logic [CW-1:0]    MAX_B      = CW'(MAX_BYTES_PER_CS);
  localparam logic [CYC_W-1:0] SETUP_LAST = CYC_W'(CS_SETUP_CLKS - 1);
  localparam logic [CYC_W-1:0] GAP_LAST   = CYC_W'(CS_INACTIVE_CLKS - 1);

  state_e            r_State, w_Next;
  logic [CW-1:0]     r_Bytes_Left, r_RX_Count, w_Count;
  logic [CYC_W-1:0]  r_Cyc;
  logic [7:0]        r_Byte, r_RX_Byte;
  logic              r_CS_n, r_Eng_DV, r_Eng_DV_d, r_RX_DV;
  logic              w_TX_Ready, w_Wr, w_Eng_Ready, w_Eng_RX_DV;
  logic [7:0]        w_Eng_RX_Byte;

  SPI_Master #(
    .SPI_MODE          (SPI_MODE),
    .CLKS_PER_HALF_BIT (CLKS_PER_HALF_BIT)
  ) u_engine (
    .i_Rst_L    (i_Rst_L),
    .i_Clk      (i_Clk),
    .i_TX_Byte  (r_Byte),
    .i_TX_DV    (r_Eng_DV),
    .o_TX_Ready (w_Eng_Ready),
    .o_RX_DV    (w_Eng_RX_DV),
    .o_RX_Byte  (w_Eng_RX_Byte),
    .o_SPI_Clk  (o_SPI_Clk),
    .i_SPI_MISO (i_SPI_MISO),
    .o_SPI_MOSI (o_SPI_MOSI)
  );

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) r_State <= IDLE;
    else          r_State <= w_Next;
  end

  // The engine's ready lags its DV by a cycle, so a just-issued byte must also block acceptance.
  always_comb begin
    w_Next     = r_State;
    w_TX_Ready = 1'b0;
    unique case (r_State)
      IDLE: begin
        w_TX_Ready = w_Eng_Ready & r_CS_n;
        if (io_if.i_TX_DV && w_TX_Ready) w_Next = SETUP;
      end
      SETUP: if (r_Cyc >= SETUP_LAST) w_Next = XFER;
      XFER: begin
        w_TX_Ready = w_Eng_Ready & (r_Bytes_Left != '0) & ~r_Eng_DV & ~r_Eng_DV_d;
        if ((r_Bytes_Left == '0) && w_Eng_Ready && !r_Eng_DV && !r_Eng_DV_d && !w_Eng_RX_DV)
          w_Next = HOLD;
      end
      HOLD: w_Next = GAP;
      GAP:  if (r_Cyc >= GAP_LAST) w_Next = IDLE;
      default: w_Next = IDLE;
    endcase
  end

  assign w_Wr = io_if.i_TX_DV & w_TX_Ready;

  always_comb begin
    w_Count = io_if.i_TX_Count;
    if (io_if.i_TX_Count == '0)        w_Count = CW'(1);
    else if (io_if.i_TX_Count > MAX_B) w_Count = MAX_B;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_CS_n       <= 1'b1;
      r_Eng_DV     <= 1'b0;
      r_Eng_DV_d   <= 1'b0;
      r_Bytes_Left <= '0;
      r_Cyc        <= '0;
      r_RX_DV      <= 1'b0;
      r_RX_Byte    <= '0;
      r_RX_Count   <= '0;
    end else begin
      r_Eng_DV_d <= r_Eng_DV;
      r_Eng_DV   <= 1'b0;
      if (w_Next != r_State)              r_Cyc <= '0;
      else if (r_Cyc != {CYC_W{1'b1}})    r_Cyc <= r_Cyc + CYC_W'(1);

      r_RX_DV <= w_Eng_RX_DV & (r_State == XFER);
      if (w_Eng_RX_DV) r_RX_Byte <= w_Eng_RX_Byte;
      if (r_RX_DV && (r_RX_Count != MAX_B)) r_RX_Count <= r_RX_Count + CW'(1);

      if (r_State == IDLE && w_Wr) begin
        r_Bytes_Left <= w_Count;
        r_RX_Count   <= '0;
        r_CS_n       <= 1'b0;
      end else if ((r_State == SETUP && w_Next == XFER) || (r_State == XFER && w_Wr)) begin
        r_Eng_DV <= 1'b1;
        if (r_Bytes_Left != '0) r_Bytes_Left <= r_Bytes_Left - CW'(1);
      end else if (r_State == HOLD) begin
        r_CS_n <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (w_Wr) r_Byte <= io_if.i_TX_Byte;
  end

  assign io_if.o_TX_Ready = w_TX_Ready;
  assign io_if.o_RX_DV    = r_RX_DV;
  assign io_if.o_RX_Byte  = r_RX_Byte;
  assign io_if.o_RX_Count = r_RX_Count;
  assign o_SPI_CS_n       = r_CS_n;

endmodule
